// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding selects and load-use stall for a 5-stage pipe.
// Optional perf counters are enabled by defining FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    input  logic              in_HOLD,
    input  logic              in_FLUSH,
    input  logic              in_ID_VALID,
    input  logic [REG_AW-1:0] in_ID_RS,
    input  logic [REG_AW-1:0] in_ID_RT,
    input  logic              in_ID_USE_RT,
    input  logic [REG_AW-1:0] in_ID_RD,
    input  logic              in_ID_WE,
    input  logic              in_ID_LOAD,
`ifdef FWD_HAZARD_PERF_EN
    output logic [CNT_W-1:0]  out_STALL_CNT,
    output logic [CNT_W-1:0]  out_FWD_CNT,
`endif
    output logic              out_STALL,
    output logic [1:0]        out_CSW_A,
    output logic [1:0]        out_CSW_B
);
    // WB producers are read straight from the register file, so only EX and MEM are tracked.
    logic              r_v_ex, r_we_ex, r_ld_ex, r_v_mem, r_we_mem;
    logic [REG_AW-1:0] r_rd_ex, r_rd_mem;
    logic [1:0]        r_csw_a, r_csw_b;
    logic              w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_stall, w_kill;
    logic [1:0]        w_sel_a, w_sel_b;

    always_comb begin
        w_ex_rs  = r_v_ex & r_we_ex & (r_rd_ex == in_ID_RS) & (|in_ID_RS);
        w_ex_rt  = r_v_ex & r_we_ex & (r_rd_ex == in_ID_RT) & (|in_ID_RT);
        w_mem_rs = r_v_mem & r_we_mem & (r_rd_mem == in_ID_RS) & (|in_ID_RS);
        w_mem_rt = r_v_mem & r_we_mem & (r_rd_mem == in_ID_RT) & (|in_ID_RT);
        w_stall  = in_ID_VALID & ~in_FLUSH & r_ld_ex & (w_ex_rs | (in_ID_USE_RT & w_ex_rt));
        w_kill   = in_FLUSH | w_stall;
        w_sel_a  = (w_kill | ~in_ID_VALID) ? 2'b00 :
                   (w_ex_rs & ~r_ld_ex) ? 2'b01 : w_mem_rs ? 2'b10 : 2'b00;
        w_sel_b  = (w_kill | ~in_ID_VALID | ~in_ID_USE_RT) ? 2'b00 :
                   (w_ex_rt & ~r_ld_ex) ? 2'b01 : w_mem_rt ? 2'b10 : 2'b00;
    end

    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            r_v_ex   <= 1'b0;
            r_we_ex  <= 1'b0;
            r_ld_ex  <= 1'b0;
            r_rd_ex  <= '0;
            r_v_mem  <= 1'b0;
            r_we_mem <= 1'b0;
            r_rd_mem <= '0;
            r_csw_a  <= 2'b00;
            r_csw_b  <= 2'b00;
        end else if (!in_HOLD) begin
            r_v_ex   <= in_ID_VALID & ~w_kill;
            r_we_ex  <= in_ID_WE;
            r_ld_ex  <= in_ID_LOAD & in_ID_VALID & ~w_kill;
            r_rd_ex  <= in_ID_RD;
            r_v_mem  <= r_v_ex;
            r_we_mem <= r_we_ex;
            r_rd_mem <= r_rd_ex;
            r_csw_a  <= w_sel_a;
            r_csw_b  <= w_sel_b;
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_fwd_cnt;
    always_ff @(posedge in_CLK or posedge in_RST) begin
        if (in_RST) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!in_HOLD) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, w_stall};
            r_fwd_cnt   <= r_fwd_cnt + {{(CNT_W-1){1'b0}}, (|w_sel_a) | (|w_sel_b)};
        end
    end
    assign out_STALL_CNT = r_stall_cnt;
    assign out_FWD_CNT   = r_fwd_cnt;
`endif

    assign out_STALL = w_stall;
    assign out_CSW_A = r_csw_a;
    assign out_CSW_B = r_csw_b;
endmodule
